wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//  Wishbone classic single-transfer initiator. Takes one read/write command on a valid/ready port,
//  runs it as a single Wishbone cycle against a slave (for example the SoC system controller), and
//  returns read data and status on a valid/ready response port. Used by debug/loader logic to reach
//  the peripheral register space without the core. Adds an ack timeout so a dead slave cannot hang it.
// PARAMETERS
//  AW       32   Wishbone address width
//  TIMEOUT  255  max cycles cyc/stb stay high awaiting ack/err; range 2..65535
//  TW       $clog2(TIMEOUT+1)  timeout counter width (derived, do not override)
// PORTS
//  i_clk         in   1   clock
//  i_rst         in   1   reset: synchronous, active-high
//  i_cmd_valid   in   1   command present
//  o_cmd_ready   out  1   command accepted when valid&ready
//  i_cmd_we      in   1   1=write, 0=read
//  i_cmd_adr     in   AW  byte address
//  i_cmd_dat     in   32  write data
//  i_cmd_sel     in   4   byte enables
//  o_rsp_valid   out  1   response present
//  i_rsp_ready   in   1   response consumed when valid&ready
//  o_rsp_rdata   out  32  read data (0 for writes and failed cycles)
//  o_rsp_err     out  1   cycle ended by i_wb_err or timeout
//  o_rsp_timeout out  1   cycle ended by timeout
//  o_wb_adr      out  AW  Wishbone address
//  o_wb_dat      out  32  Wishbone write data
//  o_wb_sel      out  4   Wishbone byte select
//  o_wb_we       out  1   Wishbone write enable
//  o_wb_cyc      out  1   Wishbone cycle
//  o_wb_stb      out  1   Wishbone strobe (always equal to o_wb_cyc)
//  i_wb_rdt      in   32  Wishbone read data
//  i_wb_ack      in   1   Wishbone ack
//  i_wb_err      in   1   Wishbone error
// BEHAVIOUR
//  - All outputs are registered. Reset values: o_cmd_ready=1; every other output is 0, including o_wb_*.
//  - FSM states: IDLE -> BUS -> RESP -> IDLE. No pipelining: one command in flight.
//  - IDLE: o_cmd_ready=1. On valid&ready at edge N:
//    - latch we/adr/dat/sel onto o_wb_*;
//    - o_cmd_ready=0, and o_wb_cyc=o_wb_stb=1 from cycle N+1;
//    - clear the timeout counter; go to BUS.
//  - BUS: o_wb_adr/dat/sel/we stay stable. The timeout counter increments on each cycle with no ack/err.
//    - i_wb_ack sampled: o_rsp_rdata = we ? 0 : i_wb_rdt; err=0; timeout=0.
//    - else i_wb_err sampled: rdata=0; err=1; timeout=0.
//    - else counter==TIMEOUT-1: rdata=0; err=1; timeout=1. cyc/stb are high for exactly TIMEOUT cycles.
//    - On any of these three: o_wb_cyc/stb=0 and o_rsp_valid=1 at the next edge; go to RESP.
//    - With a slave that acks 1 cycle after seeing cyc, cyc is high for 2 cycles and o_rsp_valid
//      rises at N+3.
//  - Priority: ack > err > timeout when they land in the same cycle.
//  - RESP: o_rsp_valid and the response fields are held stable until i_rsp_ready is sampled high.
//    Then o_rsp_valid=0 and o_cmd_ready=1 at the next edge; go to IDLE. o_cmd_ready stays 0 in BUS and RESP.
//  - i_wb_ack/i_wb_err seen in IDLE or RESP (spurious or late) are ignored: no state or output change.
//  - Reset mid-operation in any state: at the next edge cyc/stb=0, rsp_valid=0, cmd_ready=1, state=IDLE.
//    Any pending command or response is discarded.
//  - o_wb_dat and o_wb_sel are driven for reads too; the slave ignores them.
// TESTING
//  1 Write we=1 adr=0x80001038 dat=0x12345678 sel=0xF, slave acks 1 cycle after cyc
//    -> cyc high 2 cycles; rsp rdata=0 err=0 timeout=0.
//  2 Read adr=0x8000103C, slave returns 0x05F5E100 with ack -> rsp_rdata=0x05F5E100, err=0.
//  3 TIMEOUT=16, slave never acks -> cyc/stb high exactly 16 cycles; rsp err=1 timeout=1 rdata=0.
//  4 Hold i_rsp_ready low 5 cycles after rsp_valid while i_cmd_valid=1
//    -> response fields stable, cmd_ready=0, no new cyc; next command accepted only after the handshake.
//  5 Assert i_rst in the 2nd BUS cycle -> next edge cyc=stb=rsp_valid=0;
//    after release cmd_ready=1 and a new read completes normally.
//  6 TIMEOUT=4: ack in the same cycle the counter hits 3 -> err=0, timeout=0, rdata taken from i_wb_rdt;
//    err+ack together -> err=0.

Source files
------------

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Wishbone classic single-transfer initiator. Accepts one read/write command on a valid/ready
//   port, runs it as a single Wishbone cycle, and returns read data plus status on a valid/ready
//   response port. An ack timeout guarantees that a dead slave cannot hang the initiator.
//
// Parameters
//   AW       Wishbone address width
//   TIMEOUT  maximum cycles cyc/stb stay high awaiting ack/err (2..65535)
//   TW       timeout counter width, derived from TIMEOUT
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_cmd_*, o_cmd_ready    command port (we, adr, dat, sel), valid/ready handshake
//   o_rsp_*, i_rsp_ready    response port (rdata, err, timeout), valid/ready handshake
//   o_wb_*, i_wb_*          Wishbone classic initiator port
//
// Every output is a register. o_wb_stb mirrors o_wb_cyc.

module wb_cmd_master #(
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 255,
   localparam int unsigned TW     = $clog2(TIMEOUT + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   // Command port
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic          i_cmd_we,
   input  logic [AW-1:0] i_cmd_adr,
   input  logic [31:0]   i_cmd_dat,
   input  logic [3:0]    i_cmd_sel,
   // Response port
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic [31:0]   o_rsp_rdata,
   output logic          o_rsp_err,
   output logic          o_rsp_timeout,
   // Wishbone initiator
   output logic [AW-1:0] o_wb_adr,
   output logic [31:0]   o_wb_dat,
   output logic [3:0]    o_wb_sel,
   output logic          o_wb_we,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   input  logic [31:0]   i_wb_rdt,
   input  logic          i_wb_ack,
   input  logic          i_wb_err
);

   typedef enum logic [1:0] {
      StIdle,
      StBus,
      StResp
   } state_e;

   localparam logic [TW-1:0] CntLast = TW'(TIMEOUT - 1);

   state_e        state;
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= StIdle;
         tmo_cnt       <= '0;
         o_cmd_ready   <= 1'b1;
         o_rsp_valid   <= 1'b0;
         o_rsp_rdata   <= '0;
         o_rsp_err     <= 1'b0;
         o_rsp_timeout <= 1'b0;
         o_wb_adr      <= '0;
         o_wb_dat      <= '0;
         o_wb_sel      <= '0;
         o_wb_we       <= 1'b0;
         o_wb_cyc      <= 1'b0;
         o_wb_stb      <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               // o_cmd_ready is always high here, so valid alone completes the handshake.
               if (i_cmd_valid) begin
                  o_wb_adr    <= i_cmd_adr;
                  o_wb_dat    <= i_cmd_dat;
                  o_wb_sel    <= i_cmd_sel;
                  o_wb_we     <= i_cmd_we;
                  o_wb_cyc    <= 1'b1;
                  o_wb_stb    <= 1'b1;
                  o_cmd_ready <= 1'b0;
                  tmo_cnt     <= '0;
                  state       <= StBus;
               end
            end

            StBus: begin
               if (i_wb_ack || i_wb_err || (tmo_cnt == CntLast)) begin
                  // Ack wins over err, err wins over timeout.
                  if (i_wb_ack) begin
                     o_rsp_rdata   <= o_wb_we ? 32'h0 : i_wb_rdt;
                     o_rsp_err     <= 1'b0;
                     o_rsp_timeout <= 1'b0;
                  end else if (i_wb_err) begin
                     o_rsp_rdata   <= 32'h0;
                     o_rsp_err     <= 1'b1;
                     o_rsp_timeout <= 1'b0;
                  end else begin
                     o_rsp_rdata   <= 32'h0;
                     o_rsp_err     <= 1'b1;
                     o_rsp_timeout <= 1'b1;
                  end
                  o_wb_cyc    <= 1'b0;
                  o_wb_stb    <= 1'b0;
                  o_rsp_valid <= 1'b1;
                  state       <= StResp;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            StResp: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  o_cmd_ready <= 1'b1;
                  state       <= StIdle;
               end
            end

            default: begin
               state       <= StIdle;
               o_cmd_ready <= 1'b1;
               o_rsp_valid <= 1'b0;
               o_wb_cyc    <= 1'b0;
               o_wb_stb    <= 1'b0;
            end
         endcase
      end
   end

endmodule
